// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and default sizing for the program loader
package prog_loader_pkg;

  localparam int DEF_IW           = 9;
  localparam int DEF_AW           = 8;
  localparam int DEF_START_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } state_t;

  // The CPU is only released while it runs or once it has halted.
  function automatic logic holds_cpu(state_t s);
    return !(s == ST_RUN || s == ST_DONE);
  endfunction

  function automatic logic is_busy(state_t s);
    return (s == ST_LOAD) || (s == ST_START) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/load_checksum.sv
// rtl/load_checksum.sv - 8-bit additive checksum accumulator with compare
module load_checksum (
  input  logic       CLK,
  input  logic       start,
  input  logic       clr,
  input  logic       acc_en,
  input  logic [7:0] acc_data,
  input  logic [7:0] cmp_data,
  output logic       match
);

  logic [7:0] sum;

  // Running mod-256 sum of the low byte of every program word written.
  always_ff @(posedge CLK) begin
    if (start || clr) begin
      sum <= 8'd0;
    end else if (acc_en) begin
      sum <= sum + acc_data;
    end
  end

  assign match = (sum == cmp_data);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - instruction-memory loader and CPU release/halt sequencer (option: PROG_LOADER_CHECKSUM_EN)
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IW           = DEF_IW,
  parameter int AW           = DEF_AW,
  parameter int START_CYCLES = DEF_START_CYCLES
) (
  input  logic          CLK,
  input  logic          start,
  input  logic          load_req,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_wdata,
  output logic          cpu_start,
  input  logic          Halt,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   word_count,
  output logic [31:0]   run_cycles
);

  localparam logic [AW:0] LAST_ADDR  = {1'b0, {AW{1'b1}}};
  localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic        take;
  logic        wr_take;
  logic        last_ok;
  logic        clr_session;
  logic [15:0] start_cnt;

  assign take = in_valid && in_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic csum_match;

  // The final word carries the checksum and never reaches memory.
  assign wr_take = take && !in_last;
  assign last_ok = csum_match && !in_data[8];

  load_checksum u_csum (
    .CLK      (CLK),
    .start    (start),
    .clr      (clr_session),
    .acc_en   (wr_take),
    .acc_data (in_data[7:0]),
    .cmp_data (in_data[7:0]),
    .match    (csum_match)
  );
`else
  assign wr_take = take;
  assign last_ok = 1'b1;
`endif

  // Next-state decode; load_req takes priority over Halt while running.
  always_comb begin
    state_next  = state;
    clr_session = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_req) begin
          state_next  = ST_LOAD;
          clr_session = 1'b1;
        end
      end
      ST_LOAD: begin
        if (take) begin
          if (in_last) begin
            state_next = last_ok ? ST_START : ST_ERROR;
          end else if (word_count == LAST_ADDR) begin
            state_next = ST_ERROR;
          end
        end
      end
      ST_START: begin
        if (start_cnt == START_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_req) begin
          state_next  = ST_LOAD;
          clr_session = 1'b1;
        end else if (Halt) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (load_req) begin
          state_next  = ST_LOAD;
          clr_session = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, memory write port, counters and registered status flags.
  always_ff @(posedge CLK) begin
    if (start) begin
      state      <= ST_IDLE;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      word_count <= '0;
      run_cycles <= '0;
      start_cnt  <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_start  <= 1'b1;
    end else begin
      state <= state_next;

      im_we <= wr_take;
      if (wr_take) begin
        im_addr  <= word_count[AW-1:0];
        im_wdata <= in_data;
      end

      if (clr_session) begin
        word_count <= '0;
      end else if (wr_take) begin
        word_count <= word_count + 1'b1;
      end

      if (state == ST_START) begin
        start_cnt <= start_cnt + 16'd1;
      end else begin
        start_cnt <= '0;
      end

      if (state == ST_START && state_next == ST_RUN) begin
        run_cycles <= '0;
      end else if (state == ST_RUN && !Halt) begin
        run_cycles <= run_cycles + 32'd1;
      end

      in_ready  <= (state_next == ST_LOAD);
      busy      <= is_busy(state_next);
      done      <= (state_next == ST_DONE);
      err       <= (state_next == ST_ERROR);
      cpu_start <= holds_cpu(state_next);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader (honours PROG_LOADER_CHECKSUM_EN)
module tb_prog_loader;

  localparam int AW = 8;
  localparam int SC = 2;

  logic        CLK = 1'b0;
  logic        start, load_req, in_valid, in_last, Halt;
  logic [8:0]  in_data;
  logic        in_ready, im_we, cpu_start, busy, done, err;
  logic [7:0]  im_addr;
  logic [8:0]  im_wdata;
  logic [8:0]  word_count;
  logic [31:0] run_cycles;

  always #5 CLK = ~CLK;

  prog_loader dut (
    .CLK        (CLK),
    .start      (start),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_start  (cpu_start),
    .Halt       (Halt),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count),
    .run_cycles (run_cycles)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wcount;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [8:0] data;
  } wr_t;
  wr_t exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every memory write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      if (im_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=addr_%0h required=no_write", im_addr);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(im_addr), 64'(e.addr));
          chk("wr_data", 64'(im_wdata), 64'(e.data));
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_im_we"}, 64'(im_we), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_cpu_start"}, 64'(cpu_start), 64'd1);
    chk({tag, "_im_addr"}, 64'(im_addr), 64'd0);
    chk({tag, "_im_wdata"}, 64'(im_wdata), 64'd0);
    chk({tag, "_word_count"}, 64'(word_count), 64'd0);
    chk({tag, "_run_cycles"}, 64'(run_cycles), 64'd0);
  endtask

  task automatic do_load_req();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    wcount   = 0;
  endtask

  // Drives the program (plus a checksum word when that option is built).
  task automatic load_prog(input logic [8:0] prog[$], input bit gaps, input bit no_last, input bit bad_csum);
    logic [7:0] sum;
    logic [8:0] w;
    bit         last, is_csum;
    int         nw, guard;
    sum = 8'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
    nw = no_last ? prog.size() : prog.size() + 1;
`else
    nw = prog.size();
`endif
    for (int i = 0; i < nw; i++) begin
      is_csum = (i >= prog.size());
      last    = !no_last && (i == nw - 1);
      if (is_csum) begin
        w = {1'b0, 8'(sum + (bad_csum ? 8'd1 : 8'd0))};
      end else begin
        w   = prog[i];
        sum = sum + w[7:0];
      end
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = w;
      in_last  = last;
      guard    = 0;
      while (!in_ready && guard < 50) begin
        step();
        guard++;
      end
      if (!in_ready) begin
        total++;
        bad++;
        $display("FAIL handshake_timeout actual=in_ready_low required=in_ready_high");
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      if (!is_csum) begin
        exp_q.push_back('{cyc + 1, 8'(wcount), w});
        wcount++;
      end
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Entered one cycle after the final handshake: START holds the CPU for SC cycles.
  task automatic release_check(input int n);
    chk("loaded_word_count", 64'(word_count), 64'(n));
    for (int j = 0; j < SC; j++) begin
      chk("hold_cpu_start", 64'(cpu_start), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    chk("release_cpu_start", 64'(cpu_start), 64'd0);
    chk("release_busy", 64'(busy), 64'd1);
  endtask

  // Called in the first RUN cycle: n cycles with Halt low, then Halt.
  task automatic run_prog(input int n);
    repeat (n) step();
    Halt = 1'b1;
    step();
    Halt = 1'b0;
    chk("halt_done", 64'(done), 64'd1);
    chk("halt_run_cycles", 64'(run_cycles), 64'(n));
    chk("halt_cpu_start", 64'(cpu_start), 64'd0);
    chk("halt_busy", 64'(busy), 64'd0);
    step();
    chk("frozen_run_cycles", 64'(run_cycles), 64'(n));
    chk("frozen_done", 64'(done), 64'd1);
  endtask

  task automatic rand_prog(output logic [8:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(9'($urandom));
  endtask

  logic [8:0] p[$];
  int n;

  initial begin
    start    = 1'b1;
    load_req = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    Halt     = 1'b0;
    wcount   = 0;
    repeat (3) step();
    check_reset("rst");
    start = 1'b0;
    step();
    check_reset("idle");

    // Fixed three-word program, then ten run cycles.
    do_load_req();
    p = {9'h1A0, 9'h0F3, 9'h1FF};
    load_prog(p, 1'b0, 1'b0, 1'b0);
    release_check(3);
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    run_prog(10);

    // Overflow: 256 words without a last marker.
    do_load_req();
    rand_prog(p, 256);
    load_prog(p, 1'b0, 1'b1, 1'b0);
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_cpu_start", 64'(cpu_start), 64'd1);
    chk("ovf_word_count", 64'(word_count), 64'd256);
    chk("ovf_in_ready", 64'(in_ready), 64'd0);
    chk("ovf_busy", 64'(busy), 64'd0);
    step();
    chk("ovf_err_hold", 64'(err), 64'd1);
    chk("ovf_queue_empty", 64'(exp_q.size()), 64'd0);

    // Abort a running program with load_req, then reload one word.
    do_load_req();
    n = $urandom_range(1, 8);
    rand_prog(p, n);
    load_prog(p, 1'b1, 1'b0, 1'b0);
    release_check(n);
    repeat (5) step();
    load_req = 1'b1;
    Halt     = 1'b1;
    step();
    load_req = 1'b0;
    Halt     = 1'b0;
    wcount   = 0;
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_cpu_start", 64'(cpu_start), 64'd1);
    chk("abort_word_count", 64'(word_count), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    rand_prog(p, 1);
    load_prog(p, 1'b0, 1'b0, 1'b0);
    release_check(1);
    run_prog($urandom_range(0, 15));

    // Randomised sessions with gapped input.
    repeat (4) begin
      do_load_req();
      n = $urandom_range(1, 20);
      rand_prog(p, n);
      load_prog(p, 1'b1, 1'b0, 1'b0);
      release_check(n);
      run_prog($urandom_range(0, 25));
    end

    // Reset mid-load, coinciding with a handshake whose write must be dropped.
    do_load_req();
    rand_prog(p, 3);
    load_prog(p, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 9'($urandom);
    start    = 1'b1;
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    check_reset("mid_load");
    chk("mid_load_queue_empty", 64'(exp_q.size()), 64'd0);
    step();

`ifdef PROG_LOADER_CHECKSUM_EN
    do_load_req();
    p = {9'h010, 9'h020};
    load_prog(p, 1'b0, 1'b0, 1'b0);
    release_check(2);
    run_prog(3);
    do_load_req();
    load_prog(p, 1'b0, 1'b0, 1'b1);
    chk("csum_bad_err", 64'(err), 64'd1);
    chk("csum_bad_word_count", 64'(word_count), 64'd2);
    chk("csum_bad_cpu_start", 64'(cpu_start), 64'd1);
`endif

    repeat (2) step();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
